id_regfile_dump_ctrl: RTL
=========================

Name: id_regfile_dump_ctrl

Overview:
Debug-side controller that sequences a full dump of the ID-stage register file over the read-only debug port.
- On a start pulse it walks every register address in turn, captures each word and serializes it MSB-byte-first onto a byte-wide valid/ready stream feeding the UART TX path.
- Sits between the debug unit (start/done/busy) and the register file's debug read port.
- The debug unit holds the pipeline enable low while o_busy is high.

Parameters:
NB_DATA, 32, register word width; must be a multiple of NB_BYTE
NB_REG, 5, register address width
SIZE_REG, 32, number of registers dumped (addresses 0..SIZE_REG-1)
NB_BYTE, 8, stream byte width

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_start  in  1  one-cycle dump request from debug unit
o_address_read_debug  out  NB_REG  address to register file debug read port
i_data_read_debug  in  NB_DATA  combinational read data from the debug port
o_tx_data  out  NB_BYTE  byte to TX
o_tx_valid  out  1  byte valid
i_tx_ready  in  1  TX accepts byte
o_busy  out  1  dump in progress
o_done  out  1  one-cycle pulse at dump end

Behaviour:
- Reset: i_reset and i_clk as already decided. Reset forces the IDLE state. All outputs are 0: address 0, tx_data 0, valid 0, busy 0, done 0. All counters and the shift register are cleared.
- Reset mid-dump: abort immediately, with no done pulse and no partial byte. The next start restarts from address 0.
- BYTES = NB_DATA/NB_BYTE (4 with the defaults).
- States:
  - IDLE: i_start=1 moves to LOAD with addr=0. i_start is ignored in all other states.
  - LOAD (1 cycle): shift register <= i_data_read_debug at the current address; byte_cnt=0; then SEND.
  - SEND: o_tx_valid=1 and o_tx_data = shift register top NB_BYTE bits. A transfer occurs on a clock edge where o_tx_valid and i_tx_ready are both high.
    - On transfer with byte_cnt<BYTES-1: shift left by NB_BYTE and increment byte_cnt.
    - On transfer with byte_cnt=BYTES-1 and addr<SIZE_REG-1: increment addr and go to LOAD.
    - On transfer with byte_cnt=BYTES-1 and addr=SIZE_REG-1: go to DONE.
    - Without a transfer, data and valid hold stable.
  - DONE (1 cycle): o_done=1, then IDLE.
- o_busy = 1 in LOAD, SEND and DONE.
- o_address_read_debug is registered and is held for the whole dump of the current word.
- o_tx_valid is never deasserted before its transfer. i_tx_ready while valid is low is ignored.
- Latency with i_tx_ready tied high, start sampled at edge k:
  - busy rises at k+1 and LOAD(reg0) occurs at k+1.
  - First valid byte at k+2.
  - Each register takes 1+BYTES cycles.
  - o_done at k+1+SIZE_REG*(1+BYTES), which is k+161 with the defaults.
  - IDLE at k+162.
- Address counter width: NB_REG bits, compared against SIZE_REG-1. It never wraps past SIZE_REG-1.
- The block never writes the register file.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, LOAD, SEND, DONE);
  - BYTES_PER_WORD = NB_DATA/NB_BYTE;
  - a byte-counter width constant, clog2(BYTES_PER_WORD).
- One natural sub-module: regfile_word_serializer. It holds the shift register, byte counter and valid/ready output, and takes load/last signals from the FSM.
- The FSM and address counter stay in the top module.

Test Plan:
- Reset values: assert i_reset 3 cycles with i_start=1 -> all outputs 0 and no dump starts. Then pulse start -> busy at the next edge and address 0.
- Full dump, ready tied high, register file at power-up contents (reg i = i) -> 128 bytes: 00 00 00 i for i=0..31 in order, o_done exactly once, 161 cycles after start.
- Written value: write reg 5 = 0xDEADBEEF, then dump -> bytes 16..23 are 00 00 00 04 DE AD BE EF.
- Backpressure: i_tx_ready random 30% duty -> o_tx_data/o_tx_valid stable while stalled, no byte lost or duplicated, same 128-byte stream as the full-dump case.
- Start while busy: pulse i_start during reg 3 -> ignored; single 128-byte stream and single done.
- Reset mid-dump: i_reset during reg 10 byte 2 -> next cycle all outputs 0, no done. A new start yields a full stream from reg 0.

Source files
------------

// File: rtl/id_regfile_dump_ctrl_pkg.sv
// Shared types and sizing helpers for the register-file dump controller.
// Holds the FSM state encoding and byte-per-word / byte-counter sizing.
package id_regfile_dump_ctrl_pkg;

  localparam int NB_DATA_DEF = 32;
  localparam int NB_BYTE_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_t;

  // Counter width that stays >= 1 even for single-byte words.
  function automatic int cnt_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int BYTES_PER_WORD = NB_DATA_DEF / NB_BYTE_DEF;
  localparam int NB_BYTE_CNT    = cnt_bits(BYTES_PER_WORD);

endpackage

// File: rtl/id_regfile_dump_ctrl_serializer.sv
// Word serializer: captures one register word and emits it MSB byte first
// on a valid/ready stream. Ports: load/word in, ready in, data/valid/xfer/last out.
module regfile_word_serializer
  import id_regfile_dump_ctrl_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               load,
  input  logic [NB_DATA-1:0] word,
  input  logic               ready,
  output logic [NB_BYTE-1:0] data,
  output logic               valid,
  output logic               xfer,
  output logic               last
);

  localparam int BYTES  = NB_DATA / NB_BYTE;
  localparam int NB_CNT = cnt_bits(BYTES);
  localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(BYTES - 1);

  logic [NB_DATA-1:0] shift_q;
  logic [NB_CNT-1:0]  cnt_q;
  logic               valid_q;

  assign data  = shift_q[NB_DATA-1 -: NB_BYTE];
  assign valid = valid_q;
  assign xfer  = valid_q & ready;
  assign last  = (cnt_q == LAST_CNT);

  // Shifting on every transfer, including the last, leaves the register
  // empty once a word is finished, so data reads 0 between words.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      shift_q <= word;
      cnt_q   <= '0;
      valid_q <= 1'b1;
    end else if (xfer) begin
      shift_q <= shift_q << NB_BYTE;
      if (last) begin
        cnt_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + NB_CNT'(1);
      end
    end
  end

endmodule

// File: rtl/id_regfile_dump_ctrl.sv
// Dumps every ID-stage register over the debug read port as a byte stream.
// Ports: start/busy/done to debug unit, debug read addr/data, tx data/valid/ready.
module id_regfile_dump_ctrl
  import id_regfile_dump_ctrl_pkg::*;
#(
  parameter int NB_DATA  = 32,
  parameter int NB_REG   = 5,
  parameter int SIZE_REG = 32,
  parameter int NB_BYTE  = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  output logic [NB_REG-1:0]  o_address_read_debug,
  input  logic [NB_DATA-1:0] i_data_read_debug,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [NB_REG-1:0] LAST_ADDR = NB_REG'(SIZE_REG - 1);

  dump_state_t       state_q;
  dump_state_t       state_d;
  logic [NB_REG-1:0] addr_q;
  logic              addr_clr;
  logic              addr_inc;
  logic              load;
  logic              xfer;
  logic              last;

  regfile_word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_ser (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .load    (load),
    .word    (i_data_read_debug),
    .ready   (i_tx_ready),
    .data    (o_tx_data),
    .valid   (o_tx_valid),
    .xfer    (xfer),
    .last    (last)
  );

  assign o_address_read_debug = addr_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (addr_clr)
        addr_q <= '0;
      else if (addr_inc)
        addr_q <= addr_q + NB_REG'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_clr = 1'b0;
    addr_inc = 1'b0;
    load     = 1'b0;
    o_busy   = 1'b1;
    o_done   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          addr_clr = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load    = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (xfer && last) begin
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            addr_inc = 1'b1;
            state_d  = ST_LOAD;
          end
        end
      end
      ST_DONE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
